// File: rtl/led_matrix_scan.sv
// led_matrix_scan: multiplexed LED-matrix scan engine. Drives one row at a
// time (one-hot) for DWELL clocks, blanks the columns for the first BLANK
// clocks of every dwell and gates them with a 16-level brightness PWM.
// Define MATRIX_DOUBLEBUF_EN to get a front/back frame buffer pair with a
// frame-synchronous swap; otherwise a single buffer is written and shown.
module led_matrix_scan #(
  parameter int COLS  = 7,
  parameter int ROWS  = 5,
  parameter int DWELL = 1024,
  parameter int BLANK = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  input  logic [3:0]              brightness,
  output logic                    swap_pending,
  output logic                    frame_start,
  output logic [COLS-1:0]         colOut,
  output logic [ROWS-1:0]         rowOut
);

  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(DWELL);

  logic [DW-1:0]   dwell_cnt;
  logic [RW-1:0]   row_idx;
  logic [3:0]      pwm_cnt;
  logic [3:0]      bright_q;
  logic            release_q;
  logic            boundary;
  logic            wr_ok;
  logic            col_en;
  logic [COLS-1:0] front_row;
  logic [COLS-1:0] buf_a [ROWS];

  assign boundary = (dwell_cnt == DW'(DWELL - 1)) && (row_idx == RW'(ROWS - 1));
  assign wr_ok    = wr_en && ({1'b0, wr_row} < (RW + 1)'(ROWS));
  assign col_en   = (dwell_cnt >= DW'(BLANK)) && (pwm_cnt < bright_q);

  // Scan timing: dwell counter, row index advancing on dwell wrap, free PWM counter
  always_ff @(posedge CLK) begin
    if (reset) begin
      dwell_cnt <= '0;
      row_idx   <= '0;
      pwm_cnt   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (dwell_cnt == DW'(DWELL - 1)) begin
        dwell_cnt <= '0;
        row_idx   <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
    end
  end

  // Brightness is sampled only on reset release and at frame boundaries
  always_ff @(posedge CLK) begin
    if (reset) begin
      bright_q  <= '0;
      release_q <= 1'b1;
    end else begin
      release_q <= 1'b0;
      if (release_q || boundary) begin
        bright_q <= brightness;
      end
    end
  end

  // Registered pin drive derived from the current counter state
  always_ff @(posedge CLK) begin
    if (reset) begin
      colOut      <= '0;
      rowOut      <= '0;
      frame_start <= 1'b0;
    end else begin
      rowOut      <= ROWS'(1) << row_idx;
      frame_start <= (dwell_cnt == '0) && (row_idx == '0);
      colOut      <= col_en ? front_row : '0;
    end
  end

`ifdef MATRIX_DOUBLEBUF_EN

  typedef enum logic {IDLE, PENDING} swap_state_t;

  swap_state_t     state;
  logic            front_sel;
  logic [COLS-1:0] buf_b [ROWS];

  assign front_row = front_sel ? buf_b[row_idx] : buf_a[row_idx];

  // Back-buffer writes plus the swap controller; a write on the swap clock
  // lands in the outgoing back buffer and so becomes part of the new front
  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= IDLE;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        if (front_sel) begin
          buf_a[wr_row] <= wr_data;
        end else begin
          buf_b[wr_row] <= wr_data;
        end
      end
      case (state)
        IDLE: begin
          if (swap_req && boundary) begin
            front_sel <= ~front_sel;
          end else if (swap_req) begin
            state        <= PENDING;
            swap_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (boundary) begin
            front_sel    <= ~front_sel;
            state        <= IDLE;
            swap_pending <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          swap_pending <= 1'b0;
        end
      endcase
    end
  end

`else

  logic unused_swap_req;

  assign unused_swap_req = swap_req;
  assign swap_pending    = 1'b0;
  assign front_row       = buf_a[row_idx];

  // Single buffer: writes go straight into the displayed frame
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        buf_a[i] <= '0;
      end
    end else if (wr_ok) begin
      buf_a[wr_row] <= wr_data;
    end
  end

`endif

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: randomized scoreboard bench for led_matrix_scan.
// A reference model computes each clock's expected pins from elapsed time
// since reset release and pushes them into a queue; a monitor pops and
// compares every clock. Build with MATRIX_DOUBLEBUF_EN to cover swapping.
module tb_led_matrix_scan;

  localparam int COLS  = 7;
  localparam int ROWS  = 5;
  localparam int DWELL = 32;
  localparam int BLANK = 2;
  localparam int FRAME = ROWS * DWELL;

  typedef struct packed {
    logic [COLS-1:0] col;
    logic [ROWS-1:0] row;
    logic            fs;
    logic            sp;
  } out_t;

  logic            clk;
  logic            reset;
  logic            wr_en;
  logic [2:0]      wr_row;
  logic [COLS-1:0] wr_data;
  logic            swap_req;
  logic [3:0]      brightness;
  logic            swap_pending;
  logic            frame_start;
  logic [COLS-1:0] colOut;
  logic [ROWS-1:0] rowOut;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   t        = 0;
  int   cycle    = 0;
  logic [3:0] cur_bright = 4'd15;
  out_t exp_q[$];

  logic [COLS-1:0] m_front [ROWS];
  logic [COLS-1:0] m_back  [ROWS];
  logic [3:0]      m_bright = '0;
  logic            m_pending = 1'b0;
  logic            m_released = 1'b1;

  led_matrix_scan #(
    .COLS (COLS),
    .ROWS (ROWS),
    .DWELL(DWELL),
    .BLANK(BLANK)
  ) dut (
    .CLK         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .brightness  (brightness),
    .swap_pending(swap_pending),
    .frame_start (frame_start),
    .colOut      (colOut),
    .rowOut      (rowOut)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position in the scan follows from time since release
  always @(posedge clk) begin
    out_t e;
    int   d;
    int   r;
    int   p;
    logic bnd;
    logic [COLS-1:0] tmp;
    e = '0;
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        m_front[i] = '0;
        m_back[i]  = '0;
      end
      m_pending  = 1'b0;
      m_bright   = '0;
      m_released = 1'b1;
      t          = 0;
    end else begin
      d   = t % DWELL;
      r   = (t / DWELL) % ROWS;
      p   = t % 16;
      bnd = ((t % FRAME) == FRAME - 1);
      e.row = 5'b00001 << r;
      e.fs  = ((t % FRAME) == 0);
      e.col = (d >= BLANK && p < int'(m_bright)) ? m_front[r] : '0;
      if (m_released || bnd) m_bright = brightness;
      m_released = 1'b0;
`ifdef MATRIX_DOUBLEBUF_EN
      if (wr_en && int'(wr_row) < ROWS) m_back[wr_row] = wr_data;
      if ((m_pending || swap_req) && bnd) begin
        for (int i = 0; i < ROWS; i++) begin
          tmp        = m_front[i];
          m_front[i] = m_back[i];
          m_back[i]  = tmp;
        end
        m_pending = 1'b0;
      end else if (swap_req) begin
        m_pending = 1'b1;
      end
`else
      if (wr_en && int'(wr_row) < ROWS) m_front[wr_row] = wr_data;
`endif
      e.sp = m_pending;
      t    = t + 1;
    end
    exp_q.push_back(e);
  end

  task automatic checkOutput(input out_t e);
    out_t act;
    act = {colOut, rowOut, frame_start, swap_pending};
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("[TB] FAIL pins_cycle%0d: got col=%h row=%b fs=%b sp=%b, expected col=%h row=%b fs=%b sp=%b",
               cycle, act.col, act.row, act.fs, act.sp, e.col, e.row, e.fs, e.sp);
    end
  endtask

  // Monitor: one registered output set per clock, checked just after the edge
  always begin
    @(posedge clk);
    #1;
    cycle++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, required one at cycle %0d", cycle);
    end else begin
      checkOutput(exp_q.pop_front());
    end
  end

  task automatic applyStimulus(input logic rst, input logic wen, input logic [2:0] wrow,
                               input logic [COLS-1:0] wdata, input logic swp);
    reset      = rst;
    wr_en      = wen;
    wr_row     = wrow;
    wr_data    = wdata;
    swap_req   = swp;
    brightness = cur_bright;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, '0, 1'b0);
  endtask

  task automatic waitPhase(input int ph);
    int guard;
    guard = 0;
    while ((t % FRAME) != ph && guard < 2 * FRAME) begin
      applyStimulus(1'b0, 1'b0, 3'd0, '0, 1'b0);
      guard++;
    end
    n_checks++;
    if ((t % FRAME) != ph) begin
      n_fail++;
      $display("[TB] FAIL wait_phase: got phase %0d, required %0d", t % FRAME, ph);
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by 500000 ns, required earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus sequence
  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0;
    brightness = cur_bright;
    @(negedge clk);
    cur_bright = 4'($urandom_range(0, 15));
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 3'd0, '0, 1'b0);

    $display("[TB] scan order with dark frame");
    cur_bright = 4'd15;
    idleCycles(200);

    $display("[TB] brightness 8 with row 0 = 55");
    cur_bright = 4'd8;
    applyStimulus(1'b0, 1'b1, 3'd0, 7'h55, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'd0, '0, 1'b1);
    idleCycles(2 * FRAME);

    $display("[TB] double-buffer write and mid-frame swap");
    cur_bright = 4'd15;
    waitPhase(20);
    applyStimulus(1'b0, 1'b1, 3'd2, 7'h7F, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'd0, '0, 1'b1);
    idleCycles(FRAME + 80);

    $display("[TB] swap and write on the frame-boundary clock");
    waitPhase(FRAME - 1);
    applyStimulus(1'b0, 1'b1, 3'd1, 7'($urandom_range(1, 127)), 1'b1);
    idleCycles(FRAME);

    $display("[TB] out-of-range row write");
    applyStimulus(1'b0, 1'b1, 3'd6, 7'h7F, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd5, 7'h3C, 1'b0);
    idleCycles(FRAME);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) cur_bright = 4'($urandom_range(0, 15));
      applyStimulus(1'b0, ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                    7'($urandom_range(0, 127)), ($urandom_range(0, 49) == 0));
    end

    $display("[TB] mid-frame reset with swap pending");
    cur_bright = 4'd15;
    waitPhase(10);
    applyStimulus(1'b0, 1'b1, 3'd4, 7'h2A, 1'b1);
    waitPhase(100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 3'd0, '0, 1'b0);
    idleCycles(FRAME + 40);

    idleCycles(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
